// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Word-addressed memory slave with fixed wait states and error reply
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int                 c_DEPTH    = 1 << DEPTH_LOG2;
    localparam int                 c_CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_next_cnt;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [WIDTH-1:0]        r_wdata;
    logic                    r_err;
    logic [WIDTH-1:0]        r_rdata;
    logic [WIDTH-1:0]        r_mem [c_DEPTH];

    logic                    w_accept;
    logic                    w_addr_bad;
    logic                    w_access;
    logic                    w_acc_we;
    logic [DEPTH_LOG2-1:0]   w_acc_idx;
    logic [WIDTH-1:0]        w_acc_wdata;

    assign w_accept   = (r_state == S_IDLE) && req_i;
    assign w_addr_bad = (addr_i[1:0] != 2'b00) || (|addr_i[WIDTH-1:DEPTH_LOG2+2]);

    // With a single wait state the access happens on the accepting edge,
    // so the live request fields are used instead of the latched copies.
    assign w_acc_we    = (r_state == S_IDLE) ? we_i                     : r_we;
    assign w_acc_idx   = (r_state == S_IDLE) ? addr_i[DEPTH_LOG2+1:2]   : r_idx;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata_i                  : r_wdata;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    if (w_addr_bad) begin
                        w_next_state = S_RESP;
                    end else if (LATENCY == 1) begin
                        w_next_state = S_RESP;
                        w_access     = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = c_CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= c_CNT_ONE) begin
                    w_next_cnt   = '0;
                    w_next_state = S_RESP;
                    w_access     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - c_CNT_ONE;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_we    <= we_i;
                r_idx   <= addr_i[DEPTH_LOG2+1:2];
                r_wdata <= wdata_i;
                r_err   <= w_addr_bad;
                if (w_addr_bad) begin
                    r_rdata <= '0;
                end
            end
            if (w_access) begin
                r_rdata <= w_acc_we ? '0 : r_mem[w_acc_idx];
            end
        end
    end

    // Storage is not reset; a store caught by reset at its access edge is dropped.
    always_ff @(posedge clk) begin
        if (rst && w_access && w_acc_we) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    assign rdata_o = r_rdata;
    assign ready_o = (r_state == S_RESP);
    assign err_o   = (r_state == S_RESP) && r_err;
    assign busy_o  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed vector bench for mem_responder (LATENCY 2 and 1 builds)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic              clk = 1'b0;
    logic [1:0]        rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    logic [1:0][31:0]  rdata;
    logic [1:0]        ready;
    logic [1:0]        err;
    logic [1:0]        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Index 0: LATENCY=2 build, index 1: LATENCY=1 build
    mem_responder #(.WIDTH(32), .DEPTH_LOG2(8), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
        .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0])
    );

    mem_responder #(.WIDTH(32), .DEPTH_LOG2(8), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
        .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Latency k = sample index after the accepting edge at which ready is seen
    task automatic run_txn(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic exp_err,
                           input logic [31:0] exp_rd, input int exp_lat,
                           input string nm);
        int k;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        tick();
        req[d] = 1'b0;
        k = 1;
        while (!ready[d] && k < 20) begin
            tick();
            k++;
        end
        check({nm, "_ready"}, {31'd0, ready[d]}, 32'd1);
        check({nm, "_lat"},   k,                 exp_lat);
        check({nm, "_err"},   {31'd0, err[d]},   {31'd0, exp_err});
        check({nm, "_rdata"}, rdata[d],          exp_rd);
        tick();
        check({nm, "_ready_drop"}, {31'd0, ready[d]}, 32'd0);
        check({nm, "_idle"},       {31'd0, busy[d]},  32'd0);
        check({nm, "_hold"},       rdata[d],          exp_rd);
    endtask

    initial begin
        int pulses;
        int last;
        logic adjacent;
        logic [9:0] mask;

        vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,         2};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};
        vecs[2]  = '{1'b0, 32'h0000_0042, 32'h0,         1'b1, 32'h0,         1};
        vecs[3]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0,         1};
        vecs[4]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0,         2};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1111_1111, 2};
        vecs[6]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0,         2};
        vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_A5A5, 2};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         1};
        vecs[9]  = '{1'b1, 32'h0000_0041, 32'hFFFF_FFFF, 1'b1, 32'h0,         1};
        vecs[10] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};

        rst = 2'b00; req = '0; we = '0; addr = '0; wdata = '0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready%0d", d), {31'd0, ready[d]}, 32'd0);
            check($sformatf("rst_busy%0d", d),  {31'd0, busy[d]},  32'd0);
            check($sformatf("rst_err%0d", d),   {31'd0, err[d]},   32'd0);
            check($sformatf("rst_rdata%0d", d), rdata[d],          32'd0);
        end
        rst = 2'b11;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
                    vecs[i].exp_rdata, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset during WAIT of a store must abort it without touching the array
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h2222_2222;
        tick();
        req[0] = 1'b0;
        check("abort_busy_wait", {31'd0, busy[0]}, 32'd1);
        rst[0] = 1'b0;
        tick();
        tick();
        check("abort_ready", {31'd0, ready[0]}, 32'd0);
        check("abort_busy",  {31'd0, busy[0]},  32'd0);
        check("abort_rdata", rdata[0],          32'd0);
        rst[0] = 1'b1;
        tick();
        run_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_1111, 2, "abort_load");

        // req held for 10 edges: accepts at e0, e3, e6, e9; ready seen after e1, e4, e7
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40; wdata[0] = 32'h0;
        pulses = 0; last = -5; adjacent = 1'b0; mask = '0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (ready[0]) begin
                pulses++;
                mask[e] = 1'b1;
                if (e - last == 1) adjacent = 1'b1;
                last = e;
            end
        end
        req[0] = 1'b0;
        check("b2b_pulses",   pulses,              32'd3);
        check("b2b_mask",     {22'd0, mask},       32'b00_1001_0010);
        check("b2b_adjacent", {31'd0, adjacent},   32'd0);
        tick();
        check("b2b_tail_ready", {31'd0, ready[0]}, 32'd1);
        check("b2b_tail_rdata", rdata[0],          32'hDEAD_BEEF);
        tick();
        check("b2b_tail_idle",  {31'd0, busy[0]},  32'd0);

        // LATENCY=1 build
        run_txn(1, 1'b1, 32'h0, 32'h0000_1234, 1'b0, 32'h0,         1, "l1_store");
        run_txn(1, 1'b0, 32'h0, 32'h0,         1'b0, 32'h0000_1234, 1, "l1_load");
        run_txn(1, 1'b0, 32'h2, 32'h0,         1'b1, 32'h0,         1, "l1_misalign");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
